// File: rtl/cpu_player.sv
// Connect-four style CPU move picker: scan for a winning drop, then (optionally) a blocking drop, then a centre-first fallback.
// Optional feature: define CPU_PLAYER_BLOCK_EN to include the SCAN_BLK pass that blocks the opponent's four-in-a-row.
module cpu_player #(
  parameter logic [1:0] CPU_PIECE   = 2'b10,
  parameter logic [1:0] HUMAN_PIECE = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        term,
  input  logic [97:0] grid,
  input  logic [20:0] column_counts,
  output logic [6:0]  opt,
  output logic        move,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN_WIN,
`ifdef CPU_PLAYER_BLOCK_EN
    SCAN_BLK,
`endif
    PICK,
    DONE
  } state_e;

  localparam logic [2:0] LAST_COL = 3'd6;
  localparam logic [2:0] PICK_ORDER [7] = '{3'd3, 3'd2, 3'd4, 3'd1, 3'd5, 3'd0, 3'd6};

  state_e      state_q, state_d;
  logic [2:0]  col_idx_q, col_idx_d;
  logic [97:0] grid_q, grid_d;
  logic [20:0] counts_q, counts_d;
  logic [6:0]  opt_q, opt_d;

  logic        block_phase;
  logic [1:0]  scan_piece;
  logic        scan_hit;
  logic        pick_found;
  logic [2:0]  pick_col;

  function automatic logic [2:0] count_of(input logic [20:0] cnt, input logic [2:0] col);
    logic [4:0] base;
    base = 5'(col) * 5'd3;
    return cnt[base +: 3];
  endfunction

  // Off-board cells read as 2'b11, which never equals either piece code.
  function automatic logic [1:0] cell_at(input logic [97:0] g, input int r, input int c);
    logic [6:0] idx;
    logic [1:0] v;
    idx = 7'(2 * (7 * r + c));
    v   = 2'b11;
    if (r >= 0 && r < 7 && c >= 0 && c < 7) v = g[idx +: 2];
    return v;
  endfunction

  function automatic logic wins_at(input logic [97:0] g, input logic [20:0] cnt,
                                   input logic [2:0] col, input logic [1:0] p);
    logic [2:0] h;
    logic       hit;
    logic       go_on;
    int         r, c, dr, dc, run;
    h   = count_of(cnt, col);
    r   = int'(h);
    c   = int'(col);
    hit = 1'b0;
    for (int d = 0; d < 4; d++) begin
      case (d)
        0:       begin dr = 0; dc = 1;  end
        1:       begin dr = 1; dc = 0;  end
        2:       begin dr = 1; dc = 1;  end
        default: begin dr = 1; dc = -1; end
      endcase
      run   = 1;
      go_on = 1'b1;
      for (int s = 1; s <= 3; s++) begin
        if (go_on && cell_at(g, r + s * dr, c + s * dc) == p) run = run + 1;
        else go_on = 1'b0;
      end
      go_on = 1'b1;
      for (int s = 1; s <= 3; s++) begin
        if (go_on && cell_at(g, r - s * dr, c - s * dc) == p) run = run + 1;
        else go_on = 1'b0;
      end
      if (run >= 4) hit = 1'b1;
    end
    return hit && (h != 3'd7);
  endfunction

`ifdef CPU_PLAYER_BLOCK_EN
  assign block_phase = (state_q == SCAN_BLK);
`else
  assign block_phase = 1'b0;
`endif

  // One shared evaluator serves both scan passes; only the tested piece changes.
  assign scan_piece = block_phase ? HUMAN_PIECE : CPU_PIECE;
  assign scan_hit   = wins_at(grid_q, counts_q, col_idx_q, scan_piece);

  always_comb begin
    pick_found = 1'b0;
    pick_col   = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (!pick_found && count_of(counts_q, PICK_ORDER[i]) != 3'd7) begin
        pick_found = 1'b1;
        pick_col   = PICK_ORDER[i];
      end
    end
  end

  // NOTE: every signal written here gets its default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    grid_d    = grid_q;
    counts_d  = counts_q;
    opt_d     = opt_q;
    if (state_q != IDLE && term) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !term) begin
            grid_d    = grid;
            counts_d  = column_counts;
            col_idx_d = 3'd0;
            opt_d     = 7'd0;
            state_d   = SCAN_WIN;
          end
        end
        SCAN_WIN: begin
          if (scan_hit) begin
            opt_d   = 7'b1 << col_idx_q;
            state_d = DONE;
          end else if (col_idx_q == LAST_COL) begin
            col_idx_d = 3'd0;
`ifdef CPU_PLAYER_BLOCK_EN
            state_d   = SCAN_BLK;
`else
            state_d   = PICK;
`endif
          end else begin
            col_idx_d = col_idx_q + 3'd1;
          end
        end
`ifdef CPU_PLAYER_BLOCK_EN
        SCAN_BLK: begin
          if (scan_hit) begin
            opt_d   = 7'b1 << col_idx_q;
            state_d = DONE;
          end else if (col_idx_q == LAST_COL) begin
            col_idx_d = 3'd0;
            state_d   = PICK;
          end else begin
            col_idx_d = col_idx_q + 3'd1;
          end
        end
`endif
        PICK: begin
          if (pick_found) begin
            opt_d   = 7'b1 << pick_col;
            state_d = DONE;
          end else begin
            state_d = IDLE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers take <= so every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      col_idx_q <= 3'd0;
      grid_q    <= '0;
      counts_q  <= '0;
      opt_q     <= 7'd0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      grid_q    <= grid_d;
      counts_q  <= counts_d;
      opt_q     <= opt_d;
    end
  end

  // A term in DONE kills the strobe combinationally, in the same cycle it arrives.
  assign move = (state_q == DONE) && !term;
  assign busy = (state_q != IDLE);
  assign opt  = opt_q;

endmodule

// File: tb/tb_cpu_player.sv
// Self-checking bench for cpu_player: directed scenarios with literal expectations plus randomized boards vs. a line-window model.
module tb_cpu_player;

  localparam logic [1:0] CPU = 2'b10;
  localparam logic [1:0] HUM = 2'b01;
`ifdef CPU_PLAYER_BLOCK_EN
  localparam int BLOCK_EN = 1;
  localparam int FB_CYC   = 16;
`else
  localparam int BLOCK_EN = 0;
  localparam int FB_CYC   = 9;
`endif
  localparam int NO_MOVE_END = FB_CYC - 1;

  logic        clk = 1'b0;
  logic        rst, start, term;
  logic [97:0] grid;
  logic [20:0] column_counts;
  logic [6:0]  opt;
  logic        move, busy;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  cpu_player dut (
    .clk(clk), .rst(rst), .start(start), .term(term),
    .grid(grid), .column_counts(column_counts),
    .opt(opt), .move(move), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [1:0] piece_at(input logic [97:0] g, input int r, input int c);
    logic [97:0] t;
    t = g >> (2 * (7 * r + c));
    return t[1:0];
  endfunction

  function automatic logic [97:0] put(input logic [97:0] g, input int r, input int c, input logic [1:0] p);
    int sh;
    sh = 2 * (7 * r + c);
    return (g & ~(98'h3 << sh)) | (98'(p) << sh);
  endfunction

  function automatic logic [20:0] set_cnt(input logic [20:0] cn, input int c, input int v);
    return (cn & ~(21'h7 << (3 * c))) | (21'(v) << (3 * c));
  endfunction

  // Does any 4-cell window through (r,c) become all p once p is dropped at (r,c)?
  function automatic logic model_wins(input logic [97:0] g, input int r, input int c, input logic [1:0] p);
    int   dr [4];
    int   dc [4];
    int   rr, cc;
    logic all, hit;
    dr = '{0, 1, 1, 1};
    dc = '{1, 0, 1, -1};
    hit = 1'b0;
    for (int d = 0; d < 4; d++) begin
      for (int off = 0; off < 4; off++) begin
        all = 1'b1;
        for (int i = 0; i < 4; i++) begin
          rr = r + (i - off) * dr[d];
          cc = c + (i - off) * dc[d];
          if (rr < 0 || rr > 6 || cc < 0 || cc > 6) all = 1'b0;
          else if (!(rr == r && cc == c) && piece_at(g, rr, cc) != p) all = 1'b0;
        end
        if (all) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  // mcyc: cycle of the move strobe (0 = none); ecyc: last cycle busy is high.
  function automatic void predict(input logic [97:0] g, input logic [20:0] cn,
                                  output int mcyc, output int ecyc, output logic [6:0] oh);
    int          h   [7];
    int          ord [7];
    logic [20:0] t;
    ord  = '{3, 2, 4, 1, 5, 0, 6};
    for (int c = 0; c < 7; c++) begin
      t    = cn >> (3 * c);
      h[c] = int'(t[2:0]);
    end
    mcyc = 0;
    oh   = 7'd0;
    for (int k = 0; k < 7; k++)
      if (mcyc == 0 && h[k] < 7 && model_wins(g, h[k], k, CPU)) begin
        mcyc = k + 2;
        oh   = 7'(1 << k);
      end
    if (BLOCK_EN == 1 && mcyc == 0)
      for (int k = 0; k < 7; k++)
        if (mcyc == 0 && h[k] < 7 && model_wins(g, h[k], k, HUM)) begin
          mcyc = k + 9;
          oh   = 7'(1 << k);
        end
    if (mcyc == 0)
      for (int i = 0; i < 7; i++)
        if (mcyc == 0 && h[ord[i]] < 7) begin
          mcyc = FB_CYC;
          oh   = 7'(1 << ord[i]);
        end
    ecyc = (mcyc != 0) ? mcyc : NO_MOVE_END;
  endfunction

  logic       m_active = 1'b0;
  int         m_k, m_move, m_end;
  logic [6:0] m_oh;
  logic       exp_busy = 1'b0;
  logic       exp_move = 1'b0;
  logic [6:0] exp_opt  = 7'd0;

  // Model step at every rising edge: what the outputs must read for the coming cycle.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_active = 1'b0;
      exp_opt  = 7'd0;
    end else if (m_active && term) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_k++;
      if (m_k > m_end - 1) m_active = 1'b0;
    end else if (start && !term) begin
      predict(grid, column_counts, m_move, m_end, m_oh);
      m_active = 1'b1;
      m_k      = 0;
      exp_opt  = 7'd0;
    end
    exp_busy = m_active;
    exp_move = m_active && (m_k + 1 == m_move);
    if (exp_move) exp_opt = m_oh;
  end

  // Single compare process, sampling on the falling edge.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("busy", 32'(busy), 32'(exp_busy));
      check("move", 32'(move), 32'(exp_move && !term));
      check("opt",  32'(opt),  32'(exp_opt));
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic run_directed(input string name, input logic [97:0] g, input logic [20:0] cn,
                              input int lit_cyc, input logic [6:0] lit_opt, input int lit_idle);
    int         mc, ec, seen_cyc, idle_cyc;
    logic [6:0] oh, seen_opt;
    predict(g, cn, mc, ec, oh);
    check({name, "_model_cyc"}, 32'(mc), 32'(lit_cyc));
    check({name, "_model_opt"}, 32'(oh), 32'(lit_opt));
    grid          = g;
    column_counts = cn;
    start         = 1'b1;
    tick();
    start    = 1'b0;
    seen_cyc = 0;
    seen_opt = 7'd0;
    idle_cyc = 0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (move && seen_cyc == 0) begin
        seen_cyc = n;
        seen_opt = opt;
      end
      if (!busy && idle_cyc == 0) idle_cyc = n;
    end
    tick();
    check({name, "_move_cyc"}, 32'(seen_cyc), 32'(lit_cyc));
    check({name, "_move_opt"}, 32'(seen_opt), 32'(lit_opt));
    check({name, "_idle_cyc"}, 32'(idle_cyc), 32'(lit_idle));
  endtask

  task automatic count_moves(input int cycles, output int moves);
    moves = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (move) moves++;
    end
    tick();
  endtask

  initial begin
    logic [97:0] g;
    logic [20:0] cn;
    int          moves, abort_at, kind, h;

    rst = 1'b1; start = 1'b0; term = 1'b0;
    grid = '0; column_counts = '0;
    tick();
    tick();
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_move", 32'(move), 32'd0);
    check("reset_opt",  32'(opt),  32'd0);
    tick();
    rst = 1'b0;
    tick();

    run_directed("empty", '0, '0, FB_CYC, 7'b0001000, FB_CYC + 1);

    g = '0;
    g = put(g, 0, 1, CPU); g = put(g, 0, 2, CPU); g = put(g, 0, 3, CPU);
    cn = '0;
    cn = set_cnt(cn, 1, 1); cn = set_cnt(cn, 2, 1); cn = set_cnt(cn, 3, 1);
    run_directed("win_col0", g, cn, 2, 7'b0000001, 3);

    g = '0;
    g = put(g, 0, 5, HUM); g = put(g, 1, 5, HUM); g = put(g, 2, 5, HUM);
    cn = set_cnt('0, 5, 3);
`ifdef CPU_PLAYER_BLOCK_EN
    run_directed("block_col5", g, cn, 14, 7'b0100000, 15);
`else
    run_directed("block_col5", g, cn, 9, 7'b0001000, 10);
`endif

    g = '0;
    for (int r = 0; r < 7; r++) begin
      g = put(g, r, 2, (r % 2 == 0) ? CPU : HUM);
      g = put(g, r, 3, (r % 2 == 0) ? CPU : HUM);
    end
    cn = set_cnt(set_cnt('0, 2, 7), 3, 7);
    run_directed("cols23_full", g, cn, FB_CYC, 7'b0010000, FB_CYC + 1);

    run_directed("all_full", '0, 21'h1FFFFF, 0, 7'd0, FB_CYC);

    // term sampled at cycle 4 of a fallback search
    grid = '0; column_counts = '0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    term = 1'b1; tick(); term = 1'b0;
    @(negedge clk);
    check("term_abort_busy", 32'(busy), 32'd0);
    count_moves(20, moves);
    check("term_abort_moves", 32'(moves), 32'd0);

    // rst sampled at cycle 4 of a fallback search
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    check("rst_abort_busy", 32'(busy), 32'd0);
    count_moves(20, moves);
    check("rst_abort_moves", 32'(moves), 32'd0);

    // start while term is high in IDLE is ignored
    start = 1'b1; term = 1'b1; tick(); start = 1'b0; term = 1'b0;
    @(negedge clk);
    check("start_with_term_busy", 32'(busy), 32'd0);
    tick();

    // second start while busy yields one move only
    start = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    count_moves(24, moves);
    check("start_during_busy_moves", 32'(moves), 32'd1);

    // randomized boards with occasional aborts and stray starts
    for (int it = 0; it < 60; it++) begin
      g  = '0;
      cn = '0;
      for (int c = 0; c < 7; c++) begin
        h  = $urandom_range(0, 7);
        cn = set_cnt(cn, c, h);
        for (int r = 0; r < h; r++) g = put(g, r, c, 2'($urandom_range(1, 2)));
      end
      grid          = g;
      column_counts = cn;
      start         = 1'b1;
      tick();
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 17) : 0;
      kind     = $urandom_range(0, 1);
      for (int n = 1; n <= 20; n++) begin
        term  = (n == abort_at && kind == 0);
        rst   = (n == abort_at && kind == 1);
        start = ($urandom_range(0, 9) == 0);
        tick();
      end
      term = 1'b0; rst = 1'b0; start = 1'b0;
    end

    repeat (30) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
